video_timing_genlock: RTL
=========================

Name: video_timing_genlock

Overview:
Parametrised successor to the fixed-VGA video timing generator in the edge-detection output path. It produces HS/VS/DE and pixel counters for any resolution and sync polarity. It genlocks its counters to an upstream vertical reset pulse at a programmable line offset, which absorbs the sobel/colorspace pipeline delay, and reports lock status. It sits between the sobel output and the O_* video pins.

Parameters:
H_ACT, 640, horizontal active pixels (multiple of 8)
H_FP, 16, horizontal front porch
H_SW, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACT, 480, vertical active lines
V_FP, 10, vertical front porch
V_SW, 2, vertical sync width
V_BP, 33, vertical back porch
CNT_W, 12, counter width; must satisfy 2^CNT_W > H_TOTAL and 2^CNT_W > V_TOTAL
CH_W, 8, bits per colour channel; pixel width is 3*CH_W, packed {R,G,B}
HS_POL, 0, HS active level (0 = active-low)
VS_POL, 0, VS active level
LOCK_FRAMES, 2, consecutive matched genlock pulses needed to assert lock

Ports:
I_PCLK in 1 pixel clock; the only clock
I_RST_N in 1 asynchronous active-low reset
I_EN in 1 count enable
I_VRST in 1 genlock pulse, synchronous to I_PCLK; the rising edge is used
I_LOCK_LINE_OFS in CNT_W line loaded into vcnt on genlock
I_TP_MODE in 2 test-pattern select
I_PIX_DATA in 3*CH_W pixel input
O_DE out 1 data enable
O_HS out 1 horizontal sync
O_VS out 1 vertical sync
O_HCNT out CNT_W registered horizontal count
O_VCNT out CNT_W registered vertical count
O_PIX_DATA out 3*CH_W pixel output
O_FRAME_START out 1 one-cycle pulse at (hcnt,vcnt)=(0,0)
O_LOCKED out 1 genlock achieved

Behaviour:
- Clocking and reset: single clock I_PCLK. I_RST_N is asynchronous, active-low.
- Reset values: hcnt=0, vcnt=0, O_DE=0, O_HS=~HS_POL, O_VS=~VS_POL, O_HCNT=0, O_VCNT=0, O_PIX_DATA=0, O_FRAME_START=0, O_LOCKED=0, state=UNLOCKED, match count=0.
- Totals: H_TOTAL=H_SW+H_BP+H_ACT+H_FP; V_TOTAL likewise.
- Line order: sync, back porch, active, front porch.
- Counting: hcnt increments 0..H_TOTAL-1 and wraps; vcnt increments when hcnt wraps, 0..V_TOTAL-1, and wraps.
- Decode:
  - hs_i = hcnt<H_SW
  - vs_i = vcnt<V_SW
  - de_i = hcnt in [H_SW+H_BP, H_SW+H_BP+H_ACT) AND vcnt in [V_SW+V_BP, V_SW+V_BP+V_ACT)
- Latency: every output is registered one cycle after the counter state that produced it.
  - O_HS = hs_i ? HS_POL : ~HS_POL; O_VS likewise.
  - O_PIX_DATA = de_i ? pattern/I_PIX_DATA : 0. I_PIX_DATA is sampled in the de_i cycle, so the pixel is aligned with O_DE.
- I_EN=0: counters and FSM hold. Next cycle, O_DE=0, HS/VS go to inactive level, O_PIX_DATA=0, and O_FRAME_START=0. I_VRST edges are still tracked but not acted on.
- Edge detect: vrst_q <= I_VRST; edge = I_VRST & ~vrst_q. vrst_q resets to 0.
- Match definition: a match occurs when the free-run next count equals (0, I_LOCK_LINE_OFS).
- Genlock FSM, states UNLOCKED and LOCKED:
  - UNLOCKED, edge:
    - Matched: increment match count. When match count reaches LOCK_FRAMES, go to LOCKED and set O_LOCKED=1 next cycle.
    - Not matched: load hcnt=0, vcnt=I_LOCK_LINE_OFS next cycle and set match count=1.
  - LOCKED, edge, matched: no action.
  - LOCKED, edge, not matched: reload the counters, go to UNLOCKED, set O_LOCKED=0, set match count=1.
  - LOCKED, counters reach (0, I_LOCK_LINE_OFS) with no edge in the same cycle: this is a missed pulse. Go to UNLOCKED, set O_LOCKED=0, set match count=0. Counters keep free-running.
- Boundary handling:
  - I_LOCK_LINE_OFS >= V_TOTAL is taken modulo nothing: the value is clamped to V_TOTAL-1.
  - An edge coinciding with a natural wrap is evaluated with the match rule only; there is no double increment.
- Reset mid-line: outputs go to their reset values immediately. Counting restarts at (0,0) on the first clock after release.

Optional Feature:
TEST_PATTERN_EN. When defined, I_TP_MODE selects the active-region pixel source:
- 0: I_PIX_DATA
- 1: 8 colour bars, each H_ACT/8 wide, in order white, yellow, cyan, green, magenta, red, blue, black. Channels use full-scale or 0. The bar index comes from a width counter (no divider).
- 2: grey ramp; each channel = (hcnt-(H_SW+H_BP))[CH_W-1:0]
- 3: solid white
When TEST_PATTERN_EN is undefined, I_TP_MODE is ignored, the active-region source is always I_PIX_DATA, and no pattern logic is synthesised. Blanking output is 0 in either build.

Test Plan:
- Free-run, defaults, I_EN=1, no I_VRST -> 800 cycles/line, 525 lines/frame. 307200 O_DE cycles per frame. O_HS low 96 cycles/line, O_VS low 1600 cycles/frame. O_FRAME_START once every 420000 cycles.
- Genlock, I_LOCK_LINE_OFS=5, first I_VRST edge at arbitrary count (hcnt=123, vcnt=300), then every 420000 cycles -> next cycle O_HCNT=0, O_VCNT=5. O_LOCKED rises after the 2nd matched pulse and stays high.
- Missed pulse after lock -> O_LOCKED falls in the cycle after counters pass (0,5). Counters continue free-running. A mid-frame edge in LOCKED forces a reload and O_LOCKED=0.
- I_EN low for 50 cycles mid-active-line -> O_DE=0 and sync outputs inactive during the pause. O_HCNT frozen; the line resumes exactly where it stopped.
- Async reset asserted mid-line (no clock edge) -> all outputs take their reset values immediately. After release, O_HCNT counts 0,1,2…
- With TEST_PATTERN_EN, I_TP_MODE=1 -> active pixels 0-79 = 0xFFFFFF, 80-159 = 0xFFFF00, …, 560-639 = 0x000000. Blanking = 0.

Source files
------------

// File: rtl/video_timing_genlock.sv
// Parametrised video timing generator with genlock to an upstream vertical reset pulse.
// Optional test-pattern source is enabled by defining TEST_PATTERN_EN.
module video_timing_genlock #(
  parameter int H_ACT       = 640,
  parameter int H_FP        = 16,
  parameter int H_SW        = 96,
  parameter int H_BP        = 48,
  parameter int V_ACT       = 480,
  parameter int V_FP        = 10,
  parameter int V_SW        = 2,
  parameter int V_BP        = 33,
  parameter int CNT_W       = 12,
  parameter int CH_W        = 8,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                I_PCLK,
  input  logic                I_RST_N,
  input  logic                I_EN,
  input  logic                I_VRST,
  input  logic [CNT_W-1:0]    I_LOCK_LINE_OFS,
  input  logic [1:0]          I_TP_MODE,
  input  logic [3*CH_W-1:0]   I_PIX_DATA,
  output logic                O_DE,
  output logic                O_HS,
  output logic                O_VS,
  output logic [CNT_W-1:0]    O_HCNT,
  output logic [CNT_W-1:0]    O_VCNT,
  output logic [3*CH_W-1:0]   O_PIX_DATA,
  output logic                O_FRAME_START,
  output logic                O_LOCKED
);

  localparam int H_TOTAL     = H_SW + H_BP + H_ACT + H_FP;
  localparam int V_TOTAL     = V_SW + V_BP + V_ACT + V_FP;
  localparam int H_ACT_START = H_SW + H_BP;
  localparam int H_ACT_END   = H_ACT_START + H_ACT;
  localparam int V_ACT_START = V_SW + V_BP;
  localparam int V_ACT_END   = V_ACT_START + V_ACT;
  localparam int MC_W        = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  hcnt_reg, vcnt_reg;
  logic [CNT_W-1:0]  hcnt_next, vcnt_next;
  logic [CNT_W-1:0]  h_free, v_free, ofs_clamped;
  logic [MC_W-1:0]   match_cnt_reg;
  logic [MC_W:0]     match_cnt_inc;
  logic              vrst_q_reg;
  logic              vrst_edge, match, h_wrap, reload;
  logic              hs_i, vs_i, de_i;
  logic [3*CH_W-1:0] pix_src;

  // Free-running successor of the current count, before any genlock reload
  assign h_wrap = (hcnt_reg == CNT_W'(H_TOTAL - 1));
  assign h_free = h_wrap ? '0 : hcnt_reg + CNT_W'(1);
  assign v_free = !h_wrap ? vcnt_reg :
                  (vcnt_reg == CNT_W'(V_TOTAL - 1)) ? '0 : vcnt_reg + CNT_W'(1);

  assign ofs_clamped = (I_LOCK_LINE_OFS > CNT_W'(V_TOTAL - 1)) ? CNT_W'(V_TOTAL - 1)
                                                                : I_LOCK_LINE_OFS;
  assign match     = (h_free == '0) && (v_free == ofs_clamped);
  assign vrst_edge = I_VRST & ~vrst_q_reg;

  // An unmatched edge realigns the counters in either FSM state
  assign reload    = I_EN & vrst_edge & ~match;
  assign hcnt_next = reload ? '0 : h_free;
  assign vcnt_next = reload ? ofs_clamped : v_free;

  assign match_cnt_inc = {1'b0, match_cnt_reg} + (MC_W + 1)'(1);

  assign hs_i = (hcnt_reg < CNT_W'(H_SW));
  assign vs_i = (vcnt_reg < CNT_W'(V_SW));
  assign de_i = (hcnt_reg >= CNT_W'(H_ACT_START)) && (hcnt_reg < CNT_W'(H_ACT_END)) &&
                (vcnt_reg >= CNT_W'(V_ACT_START)) && (vcnt_reg < CNT_W'(V_ACT_END));

`ifdef TEST_PATTERN_EN
  localparam int BAR_W = H_ACT / 8;
  localparam int BW_W  = (BAR_W < 2) ? 1 : $clog2(BAR_W);

  logic [BW_W-1:0]   bar_w_reg;
  logic [2:0]        bar_idx_reg;
  logic [2:0]        bar_rgb;
  logic [CH_W-1:0]   ramp_val;
  logic [3*CH_W-1:0] bar_pix, ramp_pix;

  // Bar position tracks the current hcnt; restarts where the active region begins
  always_ff @(posedge I_PCLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      bar_w_reg   <= '0;
      bar_idx_reg <= '0;
    end else if (I_EN) begin
      if (hcnt_next == CNT_W'(H_ACT_START)) begin
        bar_w_reg   <= '0;
        bar_idx_reg <= '0;
      end else if (bar_w_reg == BW_W'(BAR_W - 1)) begin
        bar_w_reg   <= '0;
        bar_idx_reg <= bar_idx_reg + 3'd1;
      end else begin
        bar_w_reg <= bar_w_reg + BW_W'(1);
      end
    end
  end

  // {R,G,B} on/off for white, yellow, cyan, green, magenta, red, blue, black
  assign bar_rgb  = {~bar_idx_reg[1], ~bar_idx_reg[2], ~bar_idx_reg[0]};
  assign ramp_val = CH_W'(hcnt_reg) - CH_W'(H_ACT_START);

  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    assign bar_pix[gi*CH_W +: CH_W]  = {CH_W{bar_rgb[gi]}};
    assign ramp_pix[gi*CH_W +: CH_W] = ramp_val;
  end

  always_comb begin
    pix_src = I_PIX_DATA;
    case (I_TP_MODE)
      2'd1:    pix_src = bar_pix;
      2'd2:    pix_src = ramp_pix;
      2'd3:    pix_src = '1;
      default: pix_src = I_PIX_DATA;
    endcase
  end
`else
  logic unused_tp_mode;
  assign unused_tp_mode = ^I_TP_MODE;
  assign pix_src        = I_PIX_DATA;
`endif

  always_ff @(posedge I_PCLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_reg     <= UNLOCKED;
      match_cnt_reg <= '0;
      hcnt_reg      <= '0;
      vcnt_reg      <= '0;
      vrst_q_reg    <= 1'b0;
      O_DE          <= 1'b0;
      O_HS          <= ~HS_POL;
      O_VS          <= ~VS_POL;
      O_HCNT        <= '0;
      O_VCNT        <= '0;
      O_PIX_DATA    <= '0;
      O_FRAME_START <= 1'b0;
      O_LOCKED      <= 1'b0;
    end else begin
      vrst_q_reg <= I_VRST;
      O_HCNT     <= hcnt_reg;
      O_VCNT     <= vcnt_reg;
      if (I_EN) begin
        hcnt_reg      <= hcnt_next;
        vcnt_reg      <= vcnt_next;
        O_DE          <= de_i;
        O_HS          <= hs_i ? HS_POL : ~HS_POL;
        O_VS          <= vs_i ? VS_POL : ~VS_POL;
        O_PIX_DATA    <= de_i ? pix_src : '0;
        O_FRAME_START <= (hcnt_reg == '0) && (vcnt_reg == '0);
        case (state_reg)
          UNLOCKED: begin
            if (vrst_edge) begin
              if (match) begin
                match_cnt_reg <= match_cnt_inc[MC_W-1:0];
                if (match_cnt_inc >= (MC_W + 1)'(LOCK_FRAMES)) begin
                  state_reg <= LOCKED;
                  O_LOCKED  <= 1'b1;
                end
              end else begin
                match_cnt_reg <= MC_W'(1);
              end
            end
          end
          LOCKED: begin
            if (vrst_edge && !match) begin
              state_reg     <= UNLOCKED;
              O_LOCKED      <= 1'b0;
              match_cnt_reg <= MC_W'(1);
            end else if (!vrst_edge && match) begin
              // Expected pulse position passed without an edge
              state_reg     <= UNLOCKED;
              O_LOCKED      <= 1'b0;
              match_cnt_reg <= '0;
            end
          end
          default: state_reg <= UNLOCKED;
        endcase
      end else begin
        O_DE          <= 1'b0;
        O_HS          <= ~HS_POL;
        O_VS          <= ~VS_POL;
        O_PIX_DATA    <= '0;
        O_FRAME_START <= 1'b0;
      end
    end
  end

endmodule
